// File: rtl/sample_stream_fifo.sv
// Valid/ready byte FIFO that feeds sample_module's input stream.
// Registered outputs only; flush clears pointers, occupancy and the delivery counter.
module sample_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_WIDTH-1:0]       xfer_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;
  logic                  push, pop;

  // Flags come straight from the occupancy register, so s_ready never depends on m_ready.
  assign s_ready    = (level_q != LvlW'(DEPTH));
  assign m_valid    = (level_q != '0);
  assign m_data     = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign xfer_count = xfer_count_q;

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    xfer_count_d = xfer_count_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      xfer_count_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d     = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        xfer_count_d = xfer_count_q + CNT_WIDTH'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LvlW'(1);
      end else if (pop && !push) begin
        level_d = level_q - LvlW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      xfer_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // Storage is cleared on reset so m_data reads zero until the first push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_sample_stream_fifo.sv
// Directed self-checking bench for sample_stream_fifo.
// A second instance with a 4-bit counter covers counter wrap and mid-stream reset.
module tb_sample_stream_fifo;

  logic       clk;
  logic       reset_n, flush, s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data;
  logic [2:0] level;
  logic [15:0] xfer_count;

  logic       b_reset_n, b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic [7:0] b_s_data, b_m_data;
  logic [2:0] b_level;
  logic [3:0] b_xfer_count;

  int tests_run;
  int failures;

  sample_stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .level      (level),
    .xfer_count (xfer_count)
  );

  sample_stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(4)) dut_w (
    .clk        (clk),
    .reset_n    (b_reset_n),
    .flush      (b_flush),
    .s_valid    (b_s_valid),
    .s_ready    (b_s_ready),
    .s_data     (b_s_data),
    .m_valid    (b_m_valid),
    .m_ready    (b_m_ready),
    .m_data     (b_m_data),
    .level      (b_level),
    .xfer_count (b_xfer_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (m_valid !== 1'b0) begin
      failures++; $display("FAIL reset_m_valid got %b want 0", m_valid);
    end
    tests_run++;
    if (s_ready !== 1'b1) begin
      failures++; $display("FAIL reset_s_ready got %b want 1", s_ready);
    end
    tests_run++;
    if (level !== 3'd0) begin
      failures++; $display("FAIL reset_level got %0d want 0", level);
    end
    tests_run++;
    if (xfer_count !== 16'd0) begin
      failures++; $display("FAIL reset_xfer got %0d want 0", xfer_count);
    end
    tests_run++;
    if (m_data !== 8'h00) begin
      failures++; $display("FAIL reset_m_data got %h want 00", m_data);
    end
    tick();
    tick();
    reset_n = 1'b1; b_reset_n = 1'b1;
    s_valid = 1'b0; m_ready = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int bad;
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || level !== 3'd1) begin
      failures++;
      $display("FAIL single_push got v=%b d=%h lvl=%0d want v=1 d=a5 lvl=1",
               m_valid, m_data, level);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid !== 1'b1 || m_data !== 8'hA5) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      failures++; $display("FAIL single_hold got %0d unstable cycles want 0", bad);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tests_run++;
    if (level !== 3'd0 || m_valid !== 1'b0 || xfer_count !== 16'd1) begin
      failures++;
      $display("FAIL single_pop got lvl=%0d v=%b xfer=%0d want lvl=0 v=0 xfer=1",
               level, m_valid, xfer_count);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (xfer_count !== 16'd0) begin
      failures++; $display("FAIL flush_clears_xfer got %0d want 0", xfer_count);
    end
  endtask

  task automatic test_full();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      tick();
    end
    tests_run++;
    if (level !== 3'd4 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state got lvl=%0d rdy=%b want lvl=4 rdy=0", level, s_ready);
    end
    s_data = 8'h05;
    tick();
    tests_run++;
    if (level !== 3'd4 || m_data !== 8'h01) begin
      failures++;
      $display("FAIL full_reject got lvl=%0d d=%h want lvl=4 d=01", level, m_data);
    end
    // Pop while full with s_valid still high: the push must be blocked.
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tests_run++;
    if (level !== 3'd3 || s_ready !== 1'b1 || m_data !== 8'h02) begin
      failures++;
      $display("FAIL full_pop got lvl=%0d rdy=%b d=%h want lvl=3 rdy=1 d=02",
               level, s_ready, m_data);
    end
    for (int e = 2; e <= 4; e++) begin
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== 8'(e)) begin
        failures++;
        $display("FAIL full_order got v=%b d=%h want v=1 d=%h", m_valid, m_data, 8'(e));
      end
      tick();
    end
    m_ready = 1'b0;
    tests_run++;
    if (level !== 3'd0 || m_valid !== 1'b0 || xfer_count !== 16'd4) begin
      failures++;
      $display("FAIL full_drain got lvl=%0d v=%b xfer=%0d want lvl=0 v=0 xfer=4",
               level, m_valid, xfer_count);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bad = 0;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_data = 8'(k);
      tick();
      if (level !== 3'd1 || m_valid !== 1'b1 || m_data !== 8'(k)) begin
        bad++;
        $display("FAIL b2b_cycle%0d got lvl=%0d d=%h want lvl=1 d=%h",
                 k, level, m_data, 8'(k));
      end
    end
    tests_run++;
    if (bad != 0) begin
      failures++; $display("FAIL b2b_stream got %0d bad cycles want 0", bad);
    end
    tests_run++;
    if (xfer_count !== 16'd19) begin
      failures++; $display("FAIL b2b_xfer got %0d want 19", xfer_count);
    end
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    tests_run++;
    if (level !== 3'd0 || xfer_count !== 16'd20) begin
      failures++;
      $display("FAIL b2b_drain got lvl=%0d xfer=%0d want lvl=0 xfer=20", level, xfer_count);
    end
  endtask

  task automatic test_flush();
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = 8'h11; tick();
    s_data = 8'h22; tick();
    s_data = 8'h33; tick();
    tests_run++;
    if (level !== 3'd3) begin
      failures++; $display("FAIL flush_preload got lvl=%0d want 3", level);
    end
    flush = 1'b1; s_data = 8'h44; m_ready = 1'b1;
    tick();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    tests_run++;
    if (level !== 3'd0 || m_valid !== 1'b0 || xfer_count !== 16'd0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear got lvl=%0d v=%b xfer=%0d rdy=%b want 0 0 0 1",
               level, m_valid, xfer_count, s_ready);
    end
    tick();
    tests_run++;
    if (level !== 3'd0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_byte_lost got lvl=%0d v=%b want lvl=0 v=0", level, m_valid);
    end
    s_valid = 1'b1; s_data = 8'h55;
    tick();
    s_valid = 1'b0;
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'h55 || level !== 3'd1) begin
      failures++;
      $display("FAIL flush_refill got v=%b d=%h lvl=%0d want v=1 d=55 lvl=1",
               m_valid, m_data, level);
    end
  endtask

  task automatic test_wrap_and_reset();
    b_s_valid = 1'b1; b_m_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      b_s_data = 8'(k);
      tick();
      if (k == 15) begin
        tests_run++;
        if (b_xfer_count !== 4'd15) begin
          failures++; $display("FAIL wrap_pre got %0d want 15", b_xfer_count);
        end
      end
    end
    tests_run++;
    if (b_xfer_count !== 4'd0) begin
      failures++; $display("FAIL wrap_zero got %0d want 0", b_xfer_count);
    end
    b_s_valid = 1'b0;
    tick();
    tests_run++;
    if (b_xfer_count !== 4'd1 || b_level !== 3'd0) begin
      failures++;
      $display("FAIL wrap_17 got xfer=%0d lvl=%0d want xfer=1 lvl=0", b_xfer_count, b_level);
    end
    b_m_ready = 1'b0; b_s_valid = 1'b1;
    b_s_data = 8'hC3; tick();
    b_s_data = 8'h3C; tick();
    tests_run++;
    if (b_level !== 3'd2 || b_m_data !== 8'hC3) begin
      failures++;
      $display("FAIL midstream_load got lvl=%0d d=%h want lvl=2 d=c3", b_level, b_m_data);
    end
    b_reset_n = 1'b0;
    #2;
    tests_run++;
    if (b_m_valid !== 1'b0 || b_s_ready !== 1'b1 || b_level !== 3'd0 ||
        b_xfer_count !== 4'd0 || b_m_data !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got v=%b rdy=%b lvl=%0d xfer=%0d d=%h want 0 1 0 0 00",
               b_m_valid, b_s_ready, b_level, b_xfer_count, b_m_data);
    end
    b_s_valid = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    clk = 1'b0;
    reset_n = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
    b_reset_n = 1'b0; b_flush = 1'b0; b_s_valid = 1'b1; b_s_data = 8'h77; b_m_ready = 1'b1;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
